// File: rtl/bus_test_pkg.sv
// Shared types for the on-chip bus test sequencer.
//   op_e        : step opcode carried in the top two bits of a ROM step word
//   state_e     : sequencer FSM states
//   step_word_t : step word layout {op, addr, data} at the default bus widths
//   step_op     : converts raw opcode bits into op_e
package bus_test_pkg;

    typedef enum logic [1:0] {
        OP_END   = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_WAIT  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_BUS,
        ST_WAIT,
        ST_NEXT,
        ST_DONE
    } state_e;

    localparam int unsigned STEP_ADDR_W = 16;
    localparam int unsigned STEP_DATA_W = 8;

    typedef struct packed {
        op_e                    op;
        logic [STEP_ADDR_W-1:0] addr;
        logic [STEP_DATA_W-1:0] data;
    } step_word_t;

    function automatic op_e step_op(input logic [1:0] bits);
        return op_e'(bits);
    endfunction

endpackage

// File: rtl/bus_test_timer.sv
// Down-counter shared by WAIT steps and the bus acknowledge timeout.
//   clk, reset_n : clock, asynchronous active-low reset
//   load, value  : load the counter with value (load wins over en)
//   en           : decrement by one per cycle, holding at zero
//   zero         : counter is zero
module bus_test_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (en && count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/bus_test_sequencer.sv
// On-chip test runner: fetches step words from a test ROM, drives them as
// bus transactions, compares read data and tallies per-test results.
//   clk, reset_n          : clock, asynchronous active-low reset
//   start                 : one-cycle pulse, begins a run from IDLE or DONE
//   rom_addr, rom_data    : step index out, step word {op, addr, data} in
//                           (rom_data valid one cycle after rom_addr)
//   bus_req/we/addr/wdata : bus master request, held until bus_ack
//   bus_rdata, bus_ack    : read data and transaction completion
//   busy, done            : run in progress / run finished (held until start)
//   cur_test              : test being executed
//   pass_count/fail_count : tests passed / failed in this run
//   fail_mask             : bit t set if test t failed
module bus_test_sequencer
    import bus_test_pkg::*;
#(
    parameter int unsigned NUM_TESTS    = 4,
    parameter int unsigned STEPS_MAX    = 16,
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned TIMEOUT      = 255,
    parameter int unsigned STOP_ON_FAIL = 0
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   start,
    output logic [$clog2(NUM_TESTS*STEPS_MAX)-1:0] rom_addr,
    input  logic [2+ADDR_W+DATA_W-1:0]             rom_data,
    output logic                                   bus_req,
    output logic                                   bus_we,
    output logic [ADDR_W-1:0]                      bus_addr,
    output logic [DATA_W-1:0]                      bus_wdata,
    input  logic [DATA_W-1:0]                      bus_rdata,
    input  logic                                   bus_ack,
    output logic                                   busy,
    output logic                                   done,
    output logic [$clog2(NUM_TESTS)-1:0]           cur_test,
    output logic [$clog2(NUM_TESTS+1)-1:0]         pass_count,
    output logic [$clog2(NUM_TESTS+1)-1:0]         fail_count,
    output logic [NUM_TESTS-1:0]                   fail_mask
);

    localparam int unsigned RA_W   = $clog2(NUM_TESTS*STEPS_MAX);
    localparam int unsigned CT_W   = $clog2(NUM_TESTS);
    localparam int unsigned CNT_W  = $clog2(NUM_TESTS+1);
    localparam int unsigned STEP_W = (STEPS_MAX > 1) ? $clog2(STEPS_MAX) : 1;
    localparam int unsigned TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned TMR_W  = (TO_W > DATA_W) ? TO_W : DATA_W;

    state_e              state, state_next;
    logic [STEP_W-1:0]   step;
    logic                test_failed;
    logic                is_read;
    logic                last_step;

    op_e                 op;
    logic [ADDR_W-1:0]   step_addr;
    logic [DATA_W-1:0]   step_data;

    logic                tmr_load;
    logic                tmr_en;
    logic [TMR_W-1:0]    tmr_value;
    logic                tmr_zero;

    assign op        = step_op(rom_data[ADDR_W+DATA_W +: 2]);
    assign step_addr = rom_data[DATA_W +: ADDR_W];
    assign step_data = rom_data[DATA_W-1:0];

    assign rom_addr  = RA_W'(cur_test) * RA_W'(STEPS_MAX) + RA_W'(step);
    assign last_step = (step == STEP_W'(STEPS_MAX - 1));
    assign busy      = (state != ST_IDLE) && (state != ST_DONE);
    assign done      = (state == ST_DONE);

    // Timer is loaded with N-1 so that a WAIT of N lasts exactly N cycles and
    // bus_req stays high for exactly TIMEOUT cycles when no ack arrives.
    bus_test_timer #(
        .WIDTH(TMR_W)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (tmr_load),
        .en      (tmr_en),
        .value   (tmr_value),
        .zero    (tmr_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tmr_load   = 1'b0;
        tmr_en     = 1'b0;
        tmr_value  = '0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) state_next = ST_FETCH;
            end
            ST_FETCH: state_next = ST_DECODE;
            ST_DECODE: begin
                case (op)
                    OP_END: state_next = ST_NEXT;
                    OP_WRITE, OP_READ: begin
                        state_next = ST_BUS;
                        tmr_load   = 1'b1;
                        tmr_value  = TMR_W'(TIMEOUT - 1);
                    end
                    default: begin
                        if (step_data == '0) begin
                            state_next = last_step ? ST_NEXT : ST_FETCH;
                        end else begin
                            state_next = ST_WAIT;
                            tmr_load   = 1'b1;
                            tmr_value  = TMR_W'(step_data) - TMR_W'(1);
                        end
                    end
                endcase
            end
            ST_BUS: begin
                tmr_en = 1'b1;
                if (bus_ack) begin
                    state_next = last_step ? ST_NEXT : ST_FETCH;
                end else if (tmr_zero) begin
                    state_next = ST_NEXT;
                end
            end
            ST_WAIT: begin
                tmr_en = 1'b1;
                if (tmr_zero) state_next = last_step ? ST_NEXT : ST_FETCH;
            end
            ST_NEXT: begin
                if (cur_test == CT_W'(NUM_TESTS - 1) ||
                    (STOP_ON_FAIL != 0 && test_failed)) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_FETCH;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Read steps keep the expected value in bus_wdata, so the compare on the
    // ack cycle needs no separate register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step        <= '0;
            cur_test    <= '0;
            pass_count  <= '0;
            fail_count  <= '0;
            fail_mask   <= '0;
            test_failed <= 1'b0;
            is_read     <= 1'b0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        step        <= '0;
                        cur_test    <= '0;
                        pass_count  <= '0;
                        fail_count  <= '0;
                        fail_mask   <= '0;
                        test_failed <= 1'b0;
                    end
                end
                ST_DECODE: begin
                    if (op == OP_WRITE || op == OP_READ) begin
                        bus_req   <= 1'b1;
                        bus_we    <= (op == OP_WRITE);
                        is_read   <= (op == OP_READ);
                        bus_addr  <= step_addr;
                        bus_wdata <= step_data;
                    end
                    if (op == OP_WAIT && step_data == '0 && !last_step) begin
                        step <= step + STEP_W'(1);
                    end
                end
                ST_BUS: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (is_read && bus_rdata != bus_wdata) test_failed <= 1'b1;
                        if (!last_step) step <= step + STEP_W'(1);
                    end else if (tmr_zero) begin
                        bus_req     <= 1'b0;
                        test_failed <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (tmr_zero && !last_step) step <= step + STEP_W'(1);
                end
                ST_NEXT: begin
                    if (test_failed) begin
                        fail_count          <= fail_count + CNT_W'(1);
                        fail_mask[cur_test] <= 1'b1;
                    end else begin
                        pass_count <= pass_count + CNT_W'(1);
                    end
                    test_failed <= 1'b0;
                    if (state_next == ST_FETCH) begin
                        cur_test <= cur_test + CT_W'(1);
                        step     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
